cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 3, meaning the ROB index width.
REQ-002 SHALL have parameter FIFO_WIDTH, default 2, meaning log2 of the per-source FIFO depth (DEPTH = 4).
REQ-003 SHALL have port clk_in, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, meaning reset; it is asynchronous and active-low.
REQ-005 SHALL have port rdy_in, input, 1, meaning the global run enable.
REQ-006 SHALL have port flush_signal, input, 1, meaning the mispredict flush.
REQ-007 SHALL have ports RS_update_en / RS_update_index / RS_update_data, input, 1 / RoB_WIDTH / 32, meaning the ALU result from the reservation station.
REQ-008 SHALL have ports LSB_update_en / LSB_update_index / LSB_update_data, input, 1 / RoB_WIDTH / 32, meaning the load/store buffer result.
REQ-009 SHALL have ports CDB_update_en / CDB_update_index / CDB_update_data, output reg, 1 / RoB_WIDTH / 32, meaning the single broadcast to the RS, LSB and ROB.
REQ-010 SHALL have ports RS_almost_full and LSB_almost_full, output, 1, meaning the per-source FIFO count >= DEPTH-1; the dispatcher uses them to stall issue.
REQ-011 SHALL have port overflow_err, output reg, 1, meaning the sticky flag for a dropped result.

Function
REQ-012 SHALL keep one FIFO per source (RS, LSB), DEPTH entries of {index, data}, with FIFO_WIDTH-bit read/write pointers that wrap modulo DEPTH and a (FIFO_WIDTH+1)-bit count.
REQ-013 SHALL form each source's candidate as: the FIFO head if count>0; else the same-cycle input if that source's _en=1; else none.
REQ-014 SHALL grant at most one candidate per cycle; when only one source has a candidate, that source wins.
REQ-015 SHALL arbitrate round-robin when both sources have candidates, using register last_grant (0=RS, 1=LSB): the winner is the source not equal to last_grant, and last_grant updates to the winner on every grant.
REQ-016 SHALL register the winner onto CDB_update_* at the edge, so a result presented to an empty, winning source appears on the CDB exactly 1 cycle later; with no grant, CDB_update_en<=0 and index/data hold.
REQ-017 SHALL pop the winner's FIFO head when the winner was a FIFO head; an input that is not broadcast directly SHALL be pushed to its source FIFO in the same cycle.
REQ-018 SHALL leave count unchanged on a simultaneous push and pop, including when count==DEPTH (no overflow in that case).
REQ-019 SHALL drop the input and set overflow_err<=1 on a push with count==DEPTH and no pop; overflow_err is cleared only by reset.
REQ-020 SHALL drive the almost_full outputs combinationally from count.
REQ-021 SHALL, on flush_signal=1 at an edge (regardless of rdy_in), zero both counts and pointers, force CDB_update_en<=0, ignore both inputs that cycle, and leave last_grant and overflow_err unchanged.
REQ-022 SHALL, when rdy_in=0 and flush_signal=0, hold every register including the CDB outputs, and ignore both inputs.

Reset
REQ-023 SHALL, while rst_in=0 and independent of clk_in, clear CDB_update_en, CDB_update_index, CDB_update_data, overflow_err, all pointers and all counts to 0, and set last_grant to 1 (RS wins first tie).
REQ-024 SHALL, on reset asserted mid-operation, discard all buffered results; the first grant after release follows REQ-015 from last_grant=1.

Structure
REQ-025 SHALL take RoB_WIDTH, the data width (32) and NON_DEP from the shared CPU package, which the reservation station, LSB and ROB also use.
REQ-026 SHALL implement each FIFO as one sub-module, cdb_fifo (push, pop, head, count), instantiated twice.

Verification
REQ-027 SHALL cover: RS_update idx=3, data=0x11 alone, FIFOs empty -> next cycle CDB en=1, idx=3, data=0x11; following cycle en=0.
REQ-028 SHALL cover: RS idx=1/0xA and LSB idx=2/0xB in the same cycle after reset -> cycle+1 CDB idx=1; cycle+2 CDB idx=2; LSB count returns to 0.
REQ-029 SHALL cover: both sources driven every cycle for 8 cycles -> CDB alternates RS, LSB; RS_almost_full asserts when RS count reaches 3; no overflow.
REQ-030 SHALL cover: fill LSB FIFO to 4 while RS holds priority, then push one more LSB result with no LSB pop -> result dropped and overflow_err=1 until reset.
REQ-031 SHALL cover: 3 entries buffered, flush_signal pulse -> next cycle CDB en=0 and counts 0; a new RS result after the flush broadcasts with 1-cycle latency.
REQ-032 SHALL cover: rdy_in=0 for 3 cycles with 2 entries buffered -> CDB outputs and counts frozen; broadcast resumes in order on rdy_in=1; rst_in low mid-stream -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU constants and the CDB source encoding used by the arbiter,
// reservation station, load/store buffer and reorder buffer.
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH  = 3;
    localparam int DATA_WIDTH = 32;

    // ROB tag reserved to mean "operand has no pending producer".
    localparam logic [ROB_WIDTH-1:0] NON_DEP = '1;

    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Small circular buffer holding {index, data} results that lost CDB arbitration.
module cdb_fifo #(
    parameter int IDX_W      = 3,
    parameter int DATA_W     = 32,
    parameter int FIFO_WIDTH = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [IDX_W-1:0]      push_index,
    input  logic [DATA_W-1:0]     push_data,
    output logic [IDX_W-1:0]      head_index,
    output logic [DATA_W-1:0]     head_data,
    output logic [FIFO_WIDTH:0]   count,
    output logic                  drop
);

    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam int CNT_W = FIFO_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [FIFO_WIDTH-1:0] rd_ptr;
    logic [FIFO_WIDTH-1:0] wr_ptr;
    logic [IDX_W-1:0]      mem_index [DEPTH];
    logic [DATA_W-1:0]     mem_data  [DEPTH];
    logic                  push_ok;

    // A push into a full buffer is only lost when no entry leaves that cycle.
    assign drop       = push & (count == FULL) & ~pop;
    assign push_ok    = push & ~drop;
    assign head_index = mem_index[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every use of the head.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_index[wr_ptr] <= push_index;
            mem_data[wr_ptr]  <= push_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging RS and LSB results onto the single common data bus,
// buffering the loser of each cycle in a per-source FIFO.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int RoB_WIDTH  = ROB_WIDTH,
    parameter int FIFO_WIDTH = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_signal,
    input  logic                  RS_update_en,
    input  logic [RoB_WIDTH-1:0]  RS_update_index,
    input  logic [DATA_WIDTH-1:0] RS_update_data,
    input  logic                  LSB_update_en,
    input  logic [RoB_WIDTH-1:0]  LSB_update_index,
    input  logic [DATA_WIDTH-1:0] LSB_update_data,
    output logic                  CDB_update_en,
    output logic [RoB_WIDTH-1:0]  CDB_update_index,
    output logic [DATA_WIDTH-1:0] CDB_update_data,
    output logic                  RS_almost_full,
    output logic                  LSB_almost_full,
    output logic                  overflow_err
);

    localparam int CNT_W = FIFO_WIDTH + 1;
    localparam logic [CNT_W-1:0] ALMOST = CNT_W'((1 << FIFO_WIDTH) - 1);

    logic [FIFO_WIDTH:0]   rs_count,      lsb_count;
    logic [RoB_WIDTH-1:0]  rs_head_index, lsb_head_index;
    logic [DATA_WIDTH-1:0] rs_head_data,  lsb_head_data;
    logic                  rs_drop,       lsb_drop;
    logic                  rs_push,       lsb_push;
    logic                  rs_pop,        lsb_pop;

    logic                  rs_has_q,      lsb_has_q;
    logic                  rs_valid,      lsb_valid;
    logic                  grant;
    logic                  active;
    src_e                  win;
    src_e                  last_grant;
    logic [RoB_WIDTH-1:0]  win_index;
    logic [DATA_WIDTH-1:0] win_data;

    assign RS_almost_full  = (rs_count  >= ALMOST);
    assign LSB_almost_full = (lsb_count >= ALMOST);

    // NOTE: every signal gets a default first so this block can never infer a latch.
    always_comb begin
        active    = rdy_in & ~flush_signal;
        rs_has_q  = (rs_count  != '0);
        lsb_has_q = (lsb_count != '0);
        rs_valid  = rs_has_q  | RS_update_en;
        lsb_valid = lsb_has_q | LSB_update_en;
        grant     = rs_valid | lsb_valid;

        win = SRC_RS;
        if (rs_valid && lsb_valid) begin
            win = (last_grant == SRC_RS) ? SRC_LSB : SRC_RS;
        end else if (lsb_valid) begin
            win = SRC_LSB;
        end

        // Buffered entries always precede the same-cycle input of that source.
        win_index = rs_has_q ? rs_head_index : RS_update_index;
        win_data  = rs_has_q ? rs_head_data  : RS_update_data;
        if (win == SRC_LSB) begin
            win_index = lsb_has_q ? lsb_head_index : LSB_update_index;
            win_data  = lsb_has_q ? lsb_head_data  : LSB_update_data;
        end

        rs_pop   = active & grant & (win == SRC_RS)  & rs_has_q;
        lsb_pop  = active & grant & (win == SRC_LSB) & lsb_has_q;
        rs_push  = active & RS_update_en  & ~(grant & (win == SRC_RS)  & ~rs_has_q);
        lsb_push = active & LSB_update_en & ~(grant & (win == SRC_LSB) & ~lsb_has_q);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            CDB_update_en    <= 1'b0;
            CDB_update_index <= '0;
            CDB_update_data  <= '0;
            overflow_err     <= 1'b0;
            last_grant       <= SRC_LSB;
        end else if (flush_signal) begin
            CDB_update_en <= 1'b0;
        end else if (rdy_in) begin
            CDB_update_en <= grant;
            if (grant) begin
                CDB_update_index <= win_index;
                CDB_update_data  <= win_data;
                last_grant       <= win;
            end
            if (rs_drop || lsb_drop) overflow_err <= 1'b1;
        end
    end

    cdb_fifo #(
        .IDX_W      (RoB_WIDTH),
        .DATA_W     (DATA_WIDTH),
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_rs_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .flush      (flush_signal),
        .push       (rs_push),
        .pop        (rs_pop),
        .push_index (RS_update_index),
        .push_data  (RS_update_data),
        .head_index (rs_head_index),
        .head_data  (rs_head_data),
        .count      (rs_count),
        .drop       (rs_drop)
    );

    cdb_fifo #(
        .IDX_W      (RoB_WIDTH),
        .DATA_W     (DATA_WIDTH),
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_lsb_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .flush      (flush_signal),
        .push       (lsb_push),
        .pop        (lsb_pop),
        .push_index (LSB_update_index),
        .push_data  (LSB_update_data),
        .head_index (lsb_head_index),
        .head_data  (lsb_head_data),
        .count      (lsb_count),
        .drop       (lsb_drop)
    );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;

    typedef struct packed {
        logic        rs_en;
        logic [2:0]  rs_idx;
        logic [31:0] rs_data;
        logic        lsb_en;
        logic [2:0]  lsb_idx;
        logic [31:0] lsb_data;
        logic        rdy;
        logic        flush;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        en;
        logic [2:0]  idx;
        logic [31:0] data;
        logic [2:0]  rs_cnt;
        logic [2:0]  lsb_cnt;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        flush_signal = 1'b0;
    logic        rs_en = 1'b0, lsb_en = 1'b0;
    logic [2:0]  rs_idx = '0, lsb_idx = '0;
    logic [31:0] rs_data = '0, lsb_data = '0;
    logic        cdb_en;
    logic [2:0]  cdb_idx;
    logic [31:0] cdb_data;
    logic        rs_af, lsb_af, ovf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    entry_t q_rs[$];
    entry_t q_lsb[$];
    logic        m_en, m_ovf, m_last_lsb;
    logic [2:0]  m_idx;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush_signal     (flush_signal),
        .RS_update_en     (rs_en),
        .RS_update_index  (rs_idx),
        .RS_update_data   (rs_data),
        .LSB_update_en    (lsb_en),
        .LSB_update_index (lsb_idx),
        .LSB_update_data  (lsb_data),
        .CDB_update_en    (cdb_en),
        .CDB_update_index (cdb_idx),
        .CDB_update_data  (cdb_data),
        .RS_almost_full   (rs_af),
        .LSB_almost_full  (lsb_af),
        .overflow_err     (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t st(input logic re, input logic [2:0] ri, input logic [31:0] rd,
                                 input logic le, input logic [2:0] li, input logic [31:0] ld,
                                 input logic rdy, input logic fl);
        st = '{re, ri, rd, le, li, ld, rdy, fl};
    endfunction

    task automatic model_reset();
        q_rs.delete();
        q_lsb.delete();
        m_en = 0; m_idx = '0; m_data = '0; m_ovf = 0; m_last_lsb = 1;
    endtask

    // One clock of behaviour: the older of (buffer head, live input) represents each
    // source, the source not granted last time wins a tie, losers are queued.
    task automatic model_step(input stim_t s);
        logic have_rs, have_lsb, from_q_rs, from_q_lsb, g, w_lsb;
        entry_t e;
        if (s.flush) begin
            q_rs.delete();
            q_lsb.delete();
            m_en = 0;
        end else if (s.rdy) begin
            from_q_rs  = q_rs.size() > 0;
            from_q_lsb = q_lsb.size() > 0;
            have_rs    = from_q_rs  || s.rs_en;
            have_lsb   = from_q_lsb || s.lsb_en;
            g     = have_rs || have_lsb;
            w_lsb = (have_rs && have_lsb) ? !m_last_lsb : have_lsb;
            m_en  = g;
            if (g) begin
                if (w_lsb) e = from_q_lsb ? q_lsb[0] : '{s.lsb_idx, s.lsb_data};
                else       e = from_q_rs  ? q_rs[0]  : '{s.rs_idx,  s.rs_data};
                m_idx = e.idx; m_data = e.data; m_last_lsb = w_lsb;
                if (w_lsb && from_q_lsb)  void'(q_lsb.pop_front());
                if (!w_lsb && from_q_rs)  void'(q_rs.pop_front());
            end
            if (s.rs_en && !(g && !w_lsb && !from_q_rs)) begin
                if (q_rs.size() == 4) m_ovf = 1;
                else q_rs.push_back('{s.rs_idx, s.rs_data});
            end
            if (s.lsb_en && !(g && w_lsb && !from_q_lsb)) begin
                if (q_lsb.size() == 4) m_ovf = 1;
                else q_lsb.push_back('{s.lsb_idx, s.lsb_data});
            end
        end
    endtask

    task automatic apply(input stim_t s);
        rs_en = s.rs_en; rs_idx = s.rs_idx; rs_data = s.rs_data;
        lsb_en = s.lsb_en; lsb_idx = s.lsb_idx; lsb_data = s.lsb_data;
        rdy_in = s.rdy; flush_signal = s.flush;
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        check("m_cdb_en",  32'(cdb_en),   32'(m_en));
        check("m_cdb_idx", 32'(cdb_idx),  32'(m_idx));
        check("m_cdb_data", cdb_data,     m_data);
        check("m_ovf",     32'(ovf),      32'(m_ovf));
        check("m_rs_af",   32'(rs_af),    32'(q_rs.size() >= 3));
        check("m_lsb_af",  32'(lsb_af),   32'(q_lsb.size() >= 3));
        check("m_rs_cnt",  32'(dut.rs_count),  32'(q_rs.size()));
        check("m_lsb_cnt", 32'(dut.lsb_count), 32'(q_lsb.size()));
    endtask

    task automatic do_reset();
        rs_en = 0; lsb_en = 0; rdy_in = 1; flush_signal = 0;
        rst_in = 0;
        #1;
        check("rst_en",   32'(cdb_en),  0);
        check("rst_idx",  32'(cdb_idx), 0);
        check("rst_data", cdb_data,     0);
        check("rst_ovf",  32'(ovf),     0);
        check("rst_rs_cnt",  32'(dut.rs_count),  0);
        check("rst_lsb_cnt", 32'(dut.lsb_count), 0);
        model_reset();
        @(negedge clk);
        rst_in = 1;
    endtask

    vec_t  tbl [9];
    stim_t idle;

    initial begin
        idle = st(0, 0, 0, 0, 0, 0, 1, 0);
        //             stimulus                                     en idx data    rs lsb ovf
        tbl[0] = '{st(1, 1, 32'hA,  1, 2, 32'hB,  1, 0), 1, 1, 32'hA,  0, 1, 0};
        tbl[1] = '{idle,                                   1, 2, 32'hB,  0, 0, 0};
        tbl[2] = '{st(1, 3, 32'h11, 0, 0, 0,      1, 0), 1, 3, 32'h11, 0, 0, 0};
        tbl[3] = '{idle,                                   0, 3, 32'h11, 0, 0, 0};
        tbl[4] = '{st(1, 6, 32'h66, 1, 7, 32'h77, 0, 0), 0, 3, 32'h11, 0, 0, 0};
        tbl[5] = '{st(1, 6, 32'h66, 1, 7, 32'h77, 0, 1), 0, 3, 32'h11, 0, 0, 0};
        tbl[6] = '{st(0, 0, 0,      1, 4, 32'h44, 1, 0), 1, 4, 32'h44, 0, 0, 0};
        tbl[7] = '{st(1, 5, 32'h55, 1, 6, 32'h66, 1, 0), 1, 5, 32'h55, 0, 1, 0};
        tbl[8] = '{idle,                                   1, 6, 32'h66, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].s);
            check($sformatf("tbl%0d_en", i),   32'(cdb_en),  32'(tbl[i].en));
            check($sformatf("tbl%0d_idx", i),  32'(cdb_idx), 32'(tbl[i].idx));
            check($sformatf("tbl%0d_data", i), cdb_data,     tbl[i].data);
            check($sformatf("tbl%0d_rs", i),   32'(dut.rs_count),  32'(tbl[i].rs_cnt));
            check($sformatf("tbl%0d_lsb", i),  32'(dut.lsb_count), 32'(tbl[i].lsb_cnt));
            check($sformatf("tbl%0d_ovf", i),  32'(ovf),     32'(tbl[i].ovf));
            check_model();
        end

        // Saturating contention: alternation, almost_full, then overflow on LSB.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(st(1, 3'(i), 32'h100 + 32'(i), 1, 3'(i), 32'h200 + 32'(i), 1, 0));
            check("alt_src", 32'(cdb_data[9:8]), (i % 2 == 0) ? 1 : 2);
            check("alt_rs_af", 32'(rs_af), 32'(i >= 5));
            check("alt_ovf", 32'(ovf), 0);
            check_model();
        end
        apply(st(0, 0, 0, 1, 7, 32'h2FF, 1, 0));
        check("ovf_set", 32'(ovf), 1);
        check("ovf_lsb_cnt", 32'(dut.lsb_count), 4);
        check("ovf_rs_cnt", 32'(dut.rs_count), 3);
        check_model();
        for (int i = 0; i < 10; i++) begin
            apply(idle);
            check_model();
        end
        check("ovf_sticky", 32'(ovf), 1);

        // Flush with three entries buffered.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(st(1, 3'(i), 32'h300 + 32'(i), 1, 3'(i), 32'h400 + 32'(i), 1, 0));
            check_model();
        end
        check("pre_flush_rs",  32'(dut.rs_count),  1);
        check("pre_flush_lsb", 32'(dut.lsb_count), 2);
        apply(st(1, 1, 32'h77, 1, 2, 32'h88, 1, 1));
        check("flush_en", 32'(cdb_en), 0);
        check("flush_rs", 32'(dut.rs_count), 0);
        check("flush_lsb", 32'(dut.lsb_count), 0);
        apply(st(1, 5, 32'h55, 0, 0, 0, 1, 0));
        check("post_flush_en", 32'(cdb_en), 1);
        check("post_flush_idx", 32'(cdb_idx), 5);
        check("post_flush_data", cdb_data, 32'h55);
        check_model();

        // Stall with two entries buffered, resume, then asynchronous reset.
        do_reset();
        apply(st(1, 1, 32'h301, 1, 2, 32'h401, 1, 0));
        apply(st(1, 3, 32'h302, 1, 4, 32'h402, 1, 0));
        check("pre_stall_data", cdb_data, 32'h401);
        for (int i = 0; i < 3; i++) begin
            apply(st(1, 6, 32'h999, 1, 7, 32'h999, 0, 0));
            check("stall_en", 32'(cdb_en), 1);
            check("stall_data", cdb_data, 32'h401);
            check("stall_rs", 32'(dut.rs_count), 1);
            check("stall_lsb", 32'(dut.lsb_count), 1);
        end
        apply(idle);
        check("resume1", cdb_data, 32'h302);
        apply(idle);
        check("resume2", cdb_data, 32'h402);
        apply(idle);
        check("resume3_en", 32'(cdb_en), 0);
        check_model();
        apply(st(1, 5, 32'h303, 1, 6, 32'h403, 1, 0));
        check("pre_rst_en", 32'(cdb_en), 1);
        #1;
        do_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            s.rs_en    = ($urandom_range(0, 99) < 60);
            s.rs_idx   = 3'($urandom);
            s.rs_data  = $urandom;
            s.lsb_en   = ($urandom_range(0, 99) < 55);
            s.lsb_idx  = 3'($urandom);
            s.lsb_data = $urandom;
            s.rdy      = ($urandom_range(0, 7) != 0);
            s.flush    = ($urandom_range(0, 39) == 0);
            apply(s);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
